// File: rtl/rom_puzzle_loader_pkg.sv
// Shared definitions for the puzzle ROM loader: board geometry, loader states,
// the decoded cell record and the digit-to-candidate-mask helper.
package rom_puzzle_loader_pkg;

    localparam int N_CELLS = 81;
    localparam int CELL_AW = 7;
    localparam int ROM_W   = 8;
    localparam int DIGIT_W = 4;
    localparam int MASK_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        SEND
    } loader_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] value;
        logic [MASK_W-1:0]  mask;
        logic               given;
    } cell_t;

    // An empty cell may still hold any digit, so every candidate bit is set.
    function automatic logic [MASK_W-1:0] digit_to_mask(input logic [DIGIT_W-1:0] digit);
        if (digit == '0) begin
            return '1;
        end
        return MASK_W'(1) << (digit - DIGIT_W'(1));
    endfunction

endpackage

// File: rtl/rom_puzzle_loader_if.sv
// Bundles the loader's ROM read port, cell stream and load status into one bus.
// master = loader side, slave = ROM/board-store/controller side.
interface rom_puzzle_loader_if
    import rom_puzzle_loader_pkg::*;
#(
    parameter int WIDTH = ROM_W,
    parameter int AW    = CELL_AW
);
    logic               start;
    logic               ROM_rd;
    logic [AW-1:0]      ROM_addr;
    logic [WIDTH-1:0]   ROM_data;
    logic               cell_valid;
    logic               cell_ready;
    logic [AW-1:0]      cell_idx;
    logic [DIGIT_W-1:0] cell_value;
    logic [MASK_W-1:0]  cell_mask;
    logic               cell_given;
    logic               busy;
    logic               done;
    logic               err;
    logic [AW-1:0]      err_idx;
    logic [AW-1:0]      given_cnt;

    modport master (
        input  start, ROM_data, cell_ready,
        output ROM_rd, ROM_addr, cell_valid, cell_idx, cell_value, cell_mask,
               cell_given, busy, done, err, err_idx, given_cnt
    );

    modport slave (
        output start, ROM_data, cell_ready,
        input  ROM_rd, ROM_addr, cell_valid, cell_idx, cell_value, cell_mask,
               cell_given, busy, done, err, err_idx, given_cnt
    );
endinterface

// File: rtl/rom_puzzle_loader_decode.sv
// Combinational ROM byte decoder: validates the byte and turns it into a cell
// record. Malformed bytes are reported and decoded as an empty cell.
module rom_puzzle_loader_decode
    import rom_puzzle_loader_pkg::*;
#(
    parameter int WIDTH = ROM_W
) (
    input  logic [WIDTH-1:0] i_data,
    output cell_t            o_cell,
    output logic             o_malformed
);

    logic [DIGIT_W-1:0] w_digit;

    assign o_malformed = (|i_data[WIDTH-1:4]) || (i_data[3:0] > 4'd9);
    assign w_digit     = o_malformed ? '0 : i_data[3:0];

    assign o_cell.value = w_digit;
    assign o_cell.mask  = digit_to_mask(w_digit);
    assign o_cell.given = (w_digit != '0);

endmodule

// File: rtl/rom_puzzle_loader.sv
// Reads the 81 puzzle cells from ROM in order, decodes each one and streams it
// to the board store over valid/ready, tracking given count and first bad cell.
module rom_puzzle_loader
    import rom_puzzle_loader_pkg::*;
#(
    parameter int WIDTH = ROM_W,
    parameter int CELLS = N_CELLS
) (
    input logic                 clk,
    input logic                 rst,
    rom_puzzle_loader_if.master bus
);

    localparam int              AW   = $clog2(CELLS);
    localparam logic [AW-1:0]   LAST = AW'(CELLS - 1);

    loader_state_e r_state;
    logic [AW-1:0] r_idx;
    logic          r_romRd;
    logic [AW-1:0] r_romAddr;
    logic          r_cellValid;
    logic [AW-1:0] r_cellIdx;
    cell_t         r_cell;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [AW-1:0] r_errIdx;
    logic [AW-1:0] r_givenCnt;

    cell_t         w_cell;
    logic          w_malformed;

    rom_puzzle_loader_decode #(.WIDTH(WIDTH)) u_decode (
        .i_data      (bus.ROM_data),
        .o_cell      (w_cell),
        .o_malformed (w_malformed)
    );

    // One ROM read per cell: the strobe is raised only on entry to RD, so a
    // stalled SEND never causes a re-read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_romRd     <= 1'b0;
            r_romAddr   <= '0;
            r_cellValid <= 1'b0;
            r_cellIdx   <= '0;
            r_cell      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_errIdx    <= '0;
            r_givenCnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_errIdx   <= '0;
                        r_givenCnt <= '0;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_romRd    <= 1'b1;
                        r_romAddr  <= '0;
                        r_state    <= RD;
                    end
                end
                RD: begin
                    r_romRd <= 1'b0;
                    r_state <= CAP;
                end
                CAP: begin
                    r_cell      <= w_cell;
                    r_cellIdx   <= r_idx;
                    r_cellValid <= 1'b1;
                    if (w_malformed) begin
                        r_err <= 1'b1;
                        if (!r_err) begin
                            r_errIdx <= r_idx;
                        end
                    end
                    r_state <= SEND;
                end
                SEND: begin
                    if (r_cellValid && bus.cell_ready) begin
                        r_cellValid <= 1'b0;
                        if (r_cell.given && (r_givenCnt != AW'(CELLS))) begin
                            r_givenCnt <= r_givenCnt + AW'(1);
                        end
                        if (r_idx == LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx     <= r_idx + AW'(1);
                            r_romRd   <= 1'b1;
                            r_romAddr <= r_idx + AW'(1);
                            r_state   <= RD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ROM_rd     = r_romRd;
    assign bus.ROM_addr   = r_romAddr;
    assign bus.cell_valid = r_cellValid;
    assign bus.cell_idx   = r_cellIdx;
    assign bus.cell_value = r_cell.value;
    assign bus.cell_mask  = r_cell.mask;
    assign bus.cell_given = r_cell.given;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_idx    = r_errIdx;
    assign bus.given_cnt  = r_givenCnt;

endmodule

// File: tb/tb_rom_puzzle_loader.sv
// Randomised directed bench for rom_puzzle_loader: a negedge-updated ROM model
// feeds the loader and every delivered cell is checked against a byte-level model.
module tb_rom_puzzle_loader;
    import rom_puzzle_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem       [N_CELLS];
    logic [3:0] expValue  [N_CELLS];
    logic [8:0] expMask   [N_CELLS];
    logic       expGiven  [N_CELLS];
    logic       expErr;
    logic [6:0] expErrIdx;
    logic [6:0] expGivenCnt;

    rom_puzzle_loader_if bus ();

    rom_puzzle_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM changes its data on the falling edge after seeing the read strobe.
    always @(negedge clk) begin
        if (bus.ROM_rd && (bus.ROM_addr < 7'(N_CELLS))) begin
            bus.ROM_data <= mem[bus.ROM_addr];
        end
    end

    function automatic logic [63:0] allOutputs();
        return {bus.ROM_rd, bus.ROM_addr, bus.cell_valid, bus.cell_idx, bus.cell_value,
                bus.cell_mask, bus.cell_given, bus.busy, bus.done, bus.err,
                bus.err_idx, bus.given_cnt};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Fill the ROM image and derive the expected stream from the byte rules:
    // any byte above 9 is malformed and reads as an empty cell.
    task automatic applyStimulus(input int mode);
        int b;
        for (int i = 0; i < N_CELLS; i++) begin
            if (mode == 2 && $urandom_range(0, 99) < 15) begin
                mem[i] = 8'($urandom_range(0, 255));
            end else begin
                mem[i] = 8'($urandom_range(0, 9));
            end
        end
        if (mode == 0) begin
            mem[0] = 8'd5;
            mem[3] = 8'd0;
        end
        if (mode == 1) begin
            mem[7]  = 8'h0A;
            mem[12] = 8'h35;
        end
        expErr      = 1'b0;
        expErrIdx   = '0;
        expGivenCnt = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            b = int'(mem[i]);
            if (b > 9) begin
                if (!expErr) expErrIdx = 7'(i);
                expErr = 1'b1;
                b = 0;
            end
            expValue[i] = 4'(b);
            expMask[i]  = (b == 0) ? 9'h1FF : 9'(1 << (b - 1));
            expGiven[i] = (b != 0);
            if (b != 0) expGivenCnt = expGivenCnt + 7'd1;
        end
    endtask

    task automatic runLoad(input int readyPct, input int pulseAt, input int abortAt,
                           input bit checkTiming);
        int          c = 0;
        int          n = 0;
        int          rdTotal = 0;
        int          rdBad = 0;
        int          rdCnt [N_CELLS];
        int          doneCycle = -1;
        bit          stalled = 0;
        bit          pulsed = 0;
        bit          ready;
        logic [20:0] cur;
        logic [20:0] snap = '0;
        for (int i = 0; i < N_CELLS; i++) rdCnt[i] = 0;

        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        while (c < 4000) begin
            @(negedge clk);
            if (bus.done) begin
                doneCycle = c;
                break;
            end
            if (c == 0) begin
                checkOutput("clear_on_start",
                            {bus.busy, bus.done, bus.err, bus.err_idx, bus.given_cnt},
                            {1'b1, 16'h0});
            end
            if (bus.ROM_rd) begin
                rdTotal++;
                if (bus.ROM_addr < 7'(N_CELLS)) rdCnt[bus.ROM_addr]++;
            end
            cur = {bus.cell_idx, bus.cell_value, bus.cell_mask, bus.cell_given};
            if (stalled) begin
                checkOutput("stall_stable", {bus.cell_valid, cur}, {1'b1, snap});
            end
            if (abortAt >= 0 && bus.cell_valid && bus.cell_idx == 7'(abortAt)) begin
                rst = 1'b0;
                #1;
                checkOutput("async_reset_abort", allOutputs(), 64'h0);
                bus.start      = 1'b0;
                bus.cell_ready = 1'b0;
                return;
            end
            if (pulseAt >= 0 && !pulsed && bus.cell_valid && bus.cell_idx == 7'(pulseAt)) begin
                bus.start = 1'b1;
                pulsed = 1;
                checkOutput("busy_at_pulse", bus.busy, 1);
            end else begin
                bus.start = 1'b0;
            end
            ready = ($urandom_range(0, 99) < readyPct);
            bus.cell_ready = ready;
            if (bus.cell_valid && ready) begin
                if (n < N_CELLS) begin
                    checkOutput($sformatf("cell%0d", n), cur,
                                {7'(n), expValue[n], expMask[n], expGiven[n]});
                end else begin
                    checkOutput("accept_overflow", n + 1, N_CELLS);
                end
                n++;
            end
            stalled = bus.cell_valid && !ready;
            snap    = cur;
            @(posedge clk);
            c++;
        end
        bus.start      = 1'b0;
        bus.cell_ready = 1'b0;

        if (doneCycle < 0) begin
            checkOutput("done_timeout", bus.done, 1);
            return;
        end
        for (int i = 0; i < N_CELLS; i++) if (rdCnt[i] != 1) rdBad++;
        checkOutput("accept_count", n, N_CELLS);
        checkOutput("rom_rd_total", rdTotal, N_CELLS);
        checkOutput("rom_rd_per_index", rdBad, 0);
        checkOutput("done_busy", {bus.done, bus.busy}, 2'b10);
        checkOutput("err", bus.err, expErr);
        checkOutput("err_idx", bus.err_idx, expErrIdx);
        checkOutput("given_cnt", bus.given_cnt, expGivenCnt);
        if (checkTiming) begin
            checkOutput("start_to_done_cycles", doneCycle, 243);
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.cell_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", allOutputs(), 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_after_reset", allOutputs(), 64'h0);

        $display("[TB] load with valid data, full throughput");
        applyStimulus(0);
        checkOutput("cell0_byte", mem[0], 8'd5);
        runLoad(100, -1, -1, 1);

        $display("[TB] load with malformed cells at 7 and 12");
        applyStimulus(1);
        runLoad(100, -1, -1, 1);

        $display("[TB] random bytes, backpressure, start pulsed while busy");
        applyStimulus(2);
        runLoad(70, 20, -1, 0);

        $display("[TB] reset mid-load at cell 40");
        applyStimulus(0);
        runLoad(100, -1, 40, 0);
        repeat (3) @(negedge clk);
        checkOutput("held_in_reset", allOutputs(), 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reload after reset");
        applyStimulus(2);
        runLoad(100, -1, -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
